binary_conv_engine: RTL and testbench
=====================================

BINARY_CONV_ENGINE -- requirements
Module: binary_conv_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16: input row width and maximum image dimension N.
REQ-002 SHALL have parameter ADDR_W, default 12: input, output and weight SRAM address width.
REQ-003 SHALL have parameter MAX_K, default 4: maximum number of kernels, range 1..15.
REQ-004 SHALL be clocked by one clock, with a synchronous, active-high reset.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- dut_run, in, 1: start pulse.
- dut_busy, out, 1: block is processing.
- dut_err, out, 1: sticky format error.
- dut_sram_read_address, out, ADDR_W: input SRAM read address.
- sram_dut_read_data, in, DATA_W: input SRAM read data.
- dut_sram_write_address, out, ADDR_W: output SRAM write address.
- dut_sram_write_data, out, DATA_W: output SRAM write data.
- dut_sram_write_enable, out, 1: output SRAM write strobe.
- dut_wmem_read_address, out, ADDR_W: weight SRAM read address.
- wmem_dut_read_data, in, 16: weight SRAM read data.

Function
REQ-006 Both SRAMs SHALL be treated as 1-cycle read latency: data is valid the cycle after the address is presented.
REQ-007 Weight memory layout:
- word 0 bits[3:0] = K, the kernel count.
- words 1..K: bits[8:0] = 3x3 kernel, row-major, bit 0 = top-left; bits[12:9] = threshold T.
REQ-008 Input memory layout, starting at address 0, is a sequence of images:
- dimension word N, then N row words.
- row word bit c = column c; bits at and above N are ignored.
- the sequence ends with a terminator word 16'hFFFF (zero-extended or truncated to DATA_W).
REQ-009 Each output pixel SHALL be 1 iff popcount(XNOR(kernel, 3x3 window)) >= T.
- T=0 gives all ones.
- T>9 gives all zeros.
REQ-010 For each image, the block SHALL write N-2 output rows; each row is K consecutive words, kernel 0 first.
- word bits[N-3:0] = outputs for columns 0..N-3.
- all higher bits are 0.
REQ-011 Output words SHALL be written to consecutive addresses starting at 0 for each run, continuing across images; the address wraps modulo 2^ADDR_W.
REQ-012 State machine:
- IDLE -> LOAD_W on dut_run.
- LOAD_W -> DIM after K and all K kernels are latched.
- DIM -> FILL for a valid N; DIM -> IDLE on the terminator or an error.
- FILL -> COMPUTE after 3 rows are buffered.
- COMPUTE -> FILL after the K writes, if rows remain (fetch 1 row, shifting the 3-row window).
- COMPUTE -> DIM after the last output row.
REQ-013 dut_run SHALL be ignored while dut_busy=1.
REQ-014 dut_busy SHALL rise the cycle after an accepted dut_run and fall the cycle after the terminator or an error is detected in DIM.
- All writes SHALL complete before dut_busy falls.
REQ-015 dut_sram_write_enable SHALL be high for exactly one cycle per output word.
- Address and data are valid in the same cycle as the enable.
- There are no gaps within one row's K words.
REQ-016 A dimension word N<3 or N>DATA_W (other than the terminator) SHALL set dut_err.
- Processing stops with no writes for that image.
- The block returns to IDLE.
REQ-017 K=0 or K>MAX_K SHALL set dut_err; the block returns to IDLE without reading input.
REQ-018 dut_err SHALL stay set until the next accepted dut_run, which clears it.
REQ-019 Kernels and thresholds SHALL be reloaded at every accepted dut_run.
REQ-020 An image with N=3 SHALL produce exactly 1 row of K words.
REQ-021 A terminator at address 0 SHALL produce zero writes; dut_busy is high for at most K+4 cycles.

Reset
REQ-022 With reset=1 at a clk edge, the following SHALL be 0 after that edge: dut_busy, dut_err, dut_sram_write_enable, all addresses, dut_sram_write_data; the state SHALL be IDLE.
REQ-023 Reset asserted mid-run SHALL abort immediately, with no further writes.
- A dut_run in the first cycle after reset deasserts SHALL be accepted.
REQ-024 Row buffers and kernel registers need no reset value.

Verification
REQ-025 K=1, kernel 9'h1FF, T=5, one 3x3 image of all-ones rows 3'b111, then terminator -> one write: addr 0, data 16'h0001; dut_busy then falls.
REQ-026 K=2, kernels 9'h1FF/T=5 and 9'h000/T=5, 16x16 image of all zeros -> 28 writes alternating 16'h0000 and 16'h3FFF, addresses 0..27.
REQ-027 Two images (N=10, then N=12), K=1 -> 8 then 10 consecutive writes at addresses 0..17, upper bits zero (data <= 16'h00FF, then <= 16'h03FF).
REQ-028 T=0 and T=10 on a random 16x16 image -> every word 16'h3FFF and 16'h0000 respectively.
REQ-029 Dimension word 2 after one valid image -> the valid image's writes complete, dut_err=1, dut_busy falls, no further writes; the next dut_run clears dut_err.
REQ-030 reset pulsed during COMPUTE of a 16x16 image -> dut_sram_write_enable=0 at the next edge and all outputs 0; a rerun produces the full, correct output from address 0.

Source files
------------

// File: rtl/binary_conv_engine_if.sv
// -----------------------------------------------------------------------------
// binary_conv_engine_if
//   Bundles the control handshake and the three SRAM ports of
//   binary_conv_engine.
//   master : engine side (drives addresses, write strobe/data, busy, err)
//   slave  : environment side (drives run and both SRAM read data buses)
//   dut_run / dut_busy / dut_err                    : start pulse and status
//   dut_sram_read_address / sram_dut_read_data      : input image SRAM
//   dut_sram_write_address/_data/_enable            : output SRAM
//   dut_wmem_read_address / wmem_dut_read_data      : weight SRAM
// -----------------------------------------------------------------------------
interface binary_conv_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              dut_run;
    logic              dut_busy;
    logic              dut_err;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    logic [ADDR_W-1:0] dut_wmem_read_address;
    logic [15:0]       wmem_dut_read_data;

    modport master (
        input  dut_run,
        output dut_busy,
        output dut_err,
        output dut_sram_read_address,
        input  sram_dut_read_data,
        output dut_sram_write_address,
        output dut_sram_write_data,
        output dut_sram_write_enable,
        output dut_wmem_read_address,
        input  wmem_dut_read_data
    );

    modport slave (
        output dut_run,
        input  dut_busy,
        input  dut_err,
        input  dut_sram_read_address,
        output sram_dut_read_data,
        input  dut_sram_write_address,
        input  dut_sram_write_data,
        input  dut_sram_write_enable,
        input  dut_wmem_read_address,
        output wmem_dut_read_data
    );
endinterface

// File: rtl/binary_conv_engine.sv
// -----------------------------------------------------------------------------
// binary_conv_engine
//   Binary 3x3 convolution over a stream of square bit images. On dut_run the
//   kernel count and K kernels/thresholds are loaded from the weight SRAM, then
//   images are read from the input SRAM until a terminator word. Each output
//   pixel is 1 when popcount(XNOR(kernel, window)) >= threshold; every output
//   row is written as K consecutive words (kernel 0 first).
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : binary_conv_engine_if.master (handshake + input/output/weight SRAM)
// -----------------------------------------------------------------------------
module binary_conv_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int MAX_K  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    binary_conv_engine_if.master bus
);
    localparam int                DIM_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] TERM  = DATA_W'(16'hFFFF);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_DIM, S_FILL, S_COMPUTE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] rd_addr, w_addr, wr_ptr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en, busy, err;
    logic              rd_vld;     // input data bus holds mem[rd_addr]
    logic              ld_vld;     // weight data bus holds word ld_idx
    logic [3:0]        ld_idx, k_cnt, kidx;
    logic [DIM_W-1:0]  n_dim, rows_left;
    logic [1:0]        fill_cnt, fill_need;
    logic [DATA_W-1:0] win0, win1, win2;   // win0 = top row of the window
    logic [8:0]        kern [MAX_K];
    logic [3:0]        thr  [MAX_K];

    logic [DATA_W-1:0] rdata;
    logic [15:0]       wdata;
    logic              k_bad, dim_term, dim_bad, last_kern, last_row, fill_done;
    logic              unused_bits;

    assign rdata       = bus.sram_dut_read_data;
    assign wdata       = bus.wmem_dut_read_data;
    assign unused_bits = ^wdata[15:13];
    assign k_bad       = (wdata[3:0] == 4'd0) || (int'(wdata[3:0]) > MAX_K);
    assign dim_term    = (rdata == TERM);
    assign dim_bad     = (rdata < DATA_W'(3)) || (rdata > DATA_W'(DATA_W));
    assign last_kern   = (kidx == k_cnt - 4'd1);
    assign last_row    = (rows_left == DIM_W'(1));
    assign fill_done   = rd_vld && (fill_cnt == fill_need - 2'd1);

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = is reserved for the combinational processes.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.dut_run) state_nxt = S_LOAD_W;
            S_LOAD_W:  if (ld_vld) begin
                           if (ld_idx == 4'd0) begin
                               if (k_bad) state_nxt = S_IDLE;
                           end else if (ld_idx == k_cnt) begin
                               state_nxt = S_DIM;
                           end
                       end
            S_DIM:     if (rd_vld) state_nxt = (dim_term || dim_bad) ? S_IDLE : S_FILL;
            S_FILL:    if (fill_done) state_nxt = S_COMPUTE;
            S_COMPUTE: if (last_kern) state_nxt = last_row ? S_DIM : S_FILL;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // One output word for kernel kidx over the current 3-row window.
    logic [8:0]        sel_kern, win_bits, match;
    logic [3:0]        sel_thr, ones;
    logic [DATA_W-1:0] conv_word;

    always_comb begin
        sel_kern  = '0;
        sel_thr   = '0;
        win_bits  = '0;
        match     = '0;
        ones      = '0;
        conv_word = '0;
        for (int i = 0; i < MAX_K; i++) begin
            if (int'(kidx) == i) begin
                sel_kern = kern[i];
                sel_thr  = thr[i];
            end
        end
        for (int c = 0; c < DATA_W - 2; c++) begin
            win_bits = {win2[c+2], win2[c+1], win2[c],
                        win1[c+2], win1[c+1], win1[c],
                        win0[c+2], win0[c+1], win0[c]};
            match = ~(win_bits ^ sel_kern);
            ones  = '0;
            for (int b = 0; b < 9; b++) ones = ones + 4'(match[b]);
            conv_word[c] = (ones >= sel_thr) && (c < int'(n_dim) - 2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            w_addr    <= '0;
            wr_ptr    <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            rd_vld    <= 1'b0;
            ld_vld    <= 1'b0;
            ld_idx    <= '0;
            k_cnt     <= '0;
            kidx      <= '0;
            n_dim     <= '0;
            rows_left <= '0;
            fill_cnt  <= '0;
            fill_need <= '0;
        end else begin
            wr_en  <= 1'b0;
            rd_vld <= 1'b1;   // cleared below whenever rd_addr moves
            case (state)
                S_IDLE: if (bus.dut_run) begin
                    busy    <= 1'b1;
                    err     <= 1'b0;
                    w_addr  <= '0;
                    rd_addr <= '0;
                    rd_vld  <= 1'b0;
                    ld_vld  <= 1'b0;
                    ld_idx  <= '0;
                    kidx    <= '0;
                    wr_ptr  <= '0;
                end
                S_LOAD_W: begin
                    // Weight reads stream one per cycle; data trails by one.
                    w_addr <= w_addr + ADDR_W'(1);
                    ld_vld <= 1'b1;
                    if (ld_vld) begin
                        ld_idx <= ld_idx + 4'd1;
                        if (ld_idx == 4'd0) begin
                            k_cnt <= wdata[3:0];
                            if (k_bad) begin
                                err  <= 1'b1;
                                busy <= 1'b0;
                            end
                        end
                    end
                end
                S_DIM: if (rd_vld) begin
                    if (dim_term) begin
                        busy <= 1'b0;
                    end else if (dim_bad) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        n_dim     <= DIM_W'(rdata);
                        rows_left <= DIM_W'(rdata) - DIM_W'(2);
                        rd_addr   <= rd_addr + ADDR_W'(1);
                        rd_vld    <= 1'b0;
                        fill_cnt  <= '0;
                        fill_need <= 2'd3;
                    end
                end
                S_FILL: if (rd_vld) begin
                    rd_addr  <= rd_addr + ADDR_W'(1);
                    rd_vld   <= 1'b0;
                    fill_cnt <= fill_cnt + 2'd1;
                end
                S_COMPUTE: begin
                    wr_en   <= 1'b1;
                    wr_data <= conv_word;
                    wr_addr <= wr_ptr;
                    wr_ptr  <= wr_ptr + ADDR_W'(1);
                    if (last_kern) begin
                        kidx      <= '0;
                        rows_left <= rows_left - DIM_W'(1);
                        fill_cnt  <= '0;
                        fill_need <= 2'd1;   // slide the window by one row
                    end else begin
                        kidx <= kidx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: window rows and kernel storage carry no reset; they are always
    // written before being read, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (state == S_FILL && rd_vld) begin
            win0 <= win1;
            win1 <= win2;
            win2 <= rdata;
        end
        if (state == S_LOAD_W && ld_vld) begin
            for (int i = 0; i < MAX_K; i++) begin
                if (int'(ld_idx) == i + 1) begin
                    kern[i] <= wdata[8:0];
                    thr[i]  <= wdata[12:9];
                end
            end
        end
    end

    assign bus.dut_busy               = busy;
    assign bus.dut_err                = err;
    assign bus.dut_sram_read_address  = rd_addr;
    assign bus.dut_sram_write_address = wr_addr;
    assign bus.dut_sram_write_data    = wr_data;
    assign bus.dut_sram_write_enable  = wr_en;
    assign bus.dut_wmem_read_address  = w_addr;
endmodule

// File: tb/tb_binary_conv_engine.sv
// -----------------------------------------------------------------------------
// tb_binary_conv_engine
//   Self-checking bench: SRAM models, a write collector and a behavioural
//   reference model that walks the image stream with plain integer loops.
// -----------------------------------------------------------------------------
module tb_binary_conv_engine;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int MAX_K  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    binary_conv_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    binary_conv_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_K(MAX_K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] imem [DEPTH];
    logic [15:0] wmem [DEPTH];

    // Both SRAMs: data valid the cycle after the address.
    always @(posedge clk) begin
        bus.sram_dut_read_data <= imem[bus.dut_sram_read_address];
        bus.wmem_dut_read_data <= wmem[bus.dut_wmem_read_address];
    end

    logic [ADDR_W-1:0] got_a [$];
    logic [15:0]       got_d [$];
    int                late_wr;
    always @(negedge clk) begin
        if (bus.dut_sram_write_enable === 1'b1) begin
            got_a.push_back(bus.dut_sram_write_address);
            got_d.push_back(bus.dut_sram_write_data);
            if (bus.dut_busy !== 1'b1) late_wr++;
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wp;
    logic [15:0] exp_d [$];
    bit          exp_err;

    task automatic put(input logic [15:0] w);
        imem[wp] = w;
        wp++;
    endtask

    task automatic add_image(input int n, input bit rnd, input logic [15:0] val);
        put(16'(n));
        for (int r = 0; r < n; r++) put(rnd ? 16'($urandom) : val);
    endtask

    task automatic set_kernel(input int idx, input logic [8:0] k, input logic [3:0] t);
        wmem[idx] = {3'($urandom), t, k};
    endtask

    task automatic set_k(input int k);
        wmem[0] = {12'($urandom), 4'(k)};
    endtask

    // Reference: walk images, count matching window bits per pixel.
    task automatic model();
        int k, p, n, t, cnt;
        logic [15:0] word, kw, row;
        exp_d.delete();
        exp_err = 1'b0;
        k = int'(wmem[0][3:0]);
        if (k == 0 || k > MAX_K) begin
            exp_err = 1'b1;
            return;
        end
        p = 0;
        forever begin
            n = int'(imem[p]);
            if (imem[p] == 16'hFFFF) break;
            if (n < 3 || n > DATA_W) begin
                exp_err = 1'b1;
                break;
            end
            for (int r = 0; r <= n - 3; r++) begin
                for (int kk = 0; kk < k; kk++) begin
                    kw   = wmem[1 + kk];
                    t    = int'(kw[12:9]);
                    word = '0;
                    for (int c = 0; c <= n - 3; c++) begin
                        cnt = 0;
                        for (int dr = 0; dr < 3; dr++) begin
                            row = imem[p + 1 + r + dr];
                            for (int dc = 0; dc < 3; dc++)
                                if (row[c + dc] == kw[dr * 3 + dc]) cnt++;
                        end
                        if (cnt >= t) word[c] = 1'b1;
                    end
                    exp_d.push_back(word);
                end
            end
            p += n + 1;
        end
    endtask

    // Called at a negedge; pulses dut_run and checks the whole run.
    task automatic do_run(input string name, input bit poke_run, output int busy_cycles);
        int cyc;
        model();
        got_a.delete();
        got_d.delete();
        late_wr = 0;
        bus.dut_run = 1'b1;
        @(negedge clk);
        bus.dut_run = 1'b0;
        n_checks++;
        if (bus.dut_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_rise: got %b expected 1", name, bus.dut_busy);
        end
        n_checks++;
        if (bus.dut_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s err_clear: got %b expected 0", name, bus.dut_err);
        end
        cyc = 0;
        while (bus.dut_busy === 1'b1 && cyc < 5000) begin
            bus.dut_run = poke_run && (cyc == 3);
            @(negedge clk);
            cyc++;
        end
        bus.dut_run = 1'b0;
        busy_cycles = cyc;
        n_checks++;
        if (cyc >= 5000) begin
            n_fail++;
            $display("FAIL %s timeout: busy still %b after %0d cycles", name, bus.dut_busy, cyc);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected %0d", name, got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_a[i] !== ADDR_W'(i) || got_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL %s word%0d: got addr %0h data %h expected addr %0h data %h",
                         name, i, got_a[i], got_d[i], ADDR_W'(i), exp_d[i]);
            end
        end
        n_checks++;
        if (bus.dut_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", name, bus.dut_err, exp_err);
        end
        n_checks++;
        if (late_wr != 0) begin
            n_fail++;
            $display("FAIL %s write_after_busy: got %0d expected 0", name, late_wr);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        n_checks++;
        if (bus.dut_busy !== 1'b0 || bus.dut_err !== 1'b0 || bus.dut_sram_write_enable !== 1'b0 ||
            bus.dut_sram_read_address !== '0 || bus.dut_sram_write_address !== '0 ||
            bus.dut_wmem_read_address !== '0 || bus.dut_sram_write_data !== '0) begin
            n_fail++;
            $display("FAIL %s reset_outputs: got busy %b err %b we %b ra %h wa %h wma %h wd %h expected all 0",
                     name, bus.dut_busy, bus.dut_err, bus.dut_sram_write_enable,
                     bus.dut_sram_read_address, bus.dut_sram_write_address,
                     bus.dut_wmem_read_address, bus.dut_sram_write_data);
        end
    endtask

    task automatic test_reset();
        int bc;
        reset = 1'b1;
        bus.dut_run = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        set_k(1);
        set_kernel(1, 9'h1FF, 4'd5);
        imem[0] = 16'hFFFF;
        reset = 1'b0;
        do_run("run_after_reset", 1'b0, bc);   // run in first cycle after reset
    endtask

    task automatic test_single_3x3();
        int bc;
        @(negedge clk);
        set_k(1);
        set_kernel(1, 9'h1FF, 4'd5);
        wp = 0;
        add_image(3, 1'b0, 16'h0007);
        put(16'hFFFF);
        do_run("single_3x3", 1'b0, bc);
        n_checks++;
        if (got_d.size() != 1 || got_d[0] !== 16'h0001 || got_a[0] !== '0) begin
            n_fail++;
            $display("FAIL single_3x3 literal: got %0d words first %h expected 1 word 0001", got_d.size(), got_d[0]);
        end
    endtask

    task automatic test_two_kernels_zero();
        int bc;
        @(negedge clk);
        set_k(2);
        set_kernel(1, 9'h1FF, 4'd5);
        set_kernel(2, 9'h000, 4'd5);
        wp = 0;
        add_image(16, 1'b0, 16'h0000);
        put(16'hFFFF);
        do_run("two_kernels_zero", 1'b0, bc);
        n_checks++;
        if (got_d.size() != 28 || got_d[26] !== 16'h0000 || got_d[27] !== 16'h3FFF) begin
            n_fail++;
            $display("FAIL two_kernels_zero literal: got %0d words last %h expected 28 words last 3fff", got_d.size(), got_d[27]);
        end
    endtask

    task automatic test_two_images();
        int bc;
        @(negedge clk);
        set_k(1);
        set_kernel(1, 9'($urandom), 4'($urandom_range(2, 7)));
        wp = 0;
        add_image(10, 1'b1, '0);
        add_image(12, 1'b1, '0);
        put(16'hFFFF);
        do_run("two_images", 1'b0, bc);
    endtask

    task automatic test_thresholds();
        int bc, bad;
        @(negedge clk);
        set_k(2);
        set_kernel(1, 9'($urandom), 4'd0);
        set_kernel(2, 9'($urandom), 4'd10);
        wp = 0;
        add_image(16, 1'b1, '0);
        put(16'hFFFF);
        do_run("thresholds", 1'b0, bc);
        bad = 0;
        for (int i = 0; i < got_d.size(); i++)
            if (got_d[i] !== ((i % 2 == 0) ? 16'h3FFF : 16'h0000)) bad++;
        n_checks++;
        if (bad != 0 || got_d.size() != 28) begin
            n_fail++;
            $display("FAIL thresholds literal: got %0d bad of %0d words expected 0 bad of 28", bad, got_d.size());
        end
    endtask

    task automatic test_bad_dim();
        int bc;
        @(negedge clk);
        set_k(3);
        for (int i = 1; i <= 3; i++) set_kernel(i, 9'($urandom), 4'($urandom_range(0, 9)));
        wp = 0;
        add_image(4, 1'b1, '0);
        put(16'd2);
        add_image(5, 1'b1, '0);
        put(16'hFFFF);
        do_run("bad_dim", 1'b0, bc);
        @(negedge clk);
        imem[0] = 16'hFFFF;
        do_run("bad_dim_rerun", 1'b0, bc);
        @(negedge clk);
        imem[0] = 16'd17;
        do_run("dim_too_big", 1'b0, bc);
    endtask

    task automatic test_bad_k();
        int bc;
        @(negedge clk);
        wp = 0;
        add_image(6, 1'b1, '0);
        put(16'hFFFF);
        set_k(0);
        do_run("k_zero", 1'b0, bc);
        @(negedge clk);
        set_k(MAX_K + 1);
        do_run("k_too_big", 1'b0, bc);
        n_checks++;
        if (bus.dut_sram_read_address !== '0) begin
            n_fail++;
            $display("FAIL k_too_big read_addr: got %0h expected 0", bus.dut_sram_read_address);
        end
    endtask

    task automatic test_terminator();
        int bc;
        @(negedge clk);
        set_k(MAX_K);
        for (int i = 1; i <= MAX_K; i++) set_kernel(i, 9'($urandom), 4'd3);
        imem[0] = 16'hFFFF;
        do_run("terminator", 1'b0, bc);
        n_checks++;
        if (bc > MAX_K + 4) begin
            n_fail++;
            $display("FAIL terminator busy_len: got %0d cycles expected <= %0d", bc, MAX_K + 4);
        end
    endtask

    task automatic test_random();
        int bc, k;
        for (int it = 0; it < 6; it++) begin
            @(negedge clk);
            k = $urandom_range(1, MAX_K);
            set_k(k);
            for (int i = 1; i <= k; i++) set_kernel(i, 9'($urandom), 4'($urandom_range(0, 11)));
            wp = 0;
            for (int im = 0; im < int'($urandom_range(1, 3)); im++)
                add_image($urandom_range(3, DATA_W), 1'b1, '0);
            put(16'hFFFF);
            do_run($sformatf("random%0d", it), it == 0, bc);  // it 0 pokes run while busy
        end
    endtask

    task automatic test_reset_mid_run();
        int bc, cyc, snap;
        @(negedge clk);
        set_k(MAX_K);
        for (int i = 1; i <= MAX_K; i++) set_kernel(i, 9'($urandom), 4'($urandom_range(3, 7)));
        wp = 0;
        add_image(16, 1'b1, '0);
        put(16'hFFFF);
        got_d.delete();
        got_a.delete();
        bus.dut_run = 1'b1;
        @(negedge clk);
        bus.dut_run = 1'b0;
        cyc = 0;
        while ((got_d.size() < 6 || bus.dut_sram_write_enable !== 1'b1) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 3000) begin
            n_fail++;
            $display("FAIL mid_reset wait_compute: got %0d writes expected >= 6", got_d.size());
        end
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("mid_reset");
        snap = got_d.size();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (got_d.size() != snap) begin
            n_fail++;
            $display("FAIL mid_reset stray_writes: got %0d expected %0d", got_d.size(), snap);
        end
        do_run("rerun_after_reset", 1'b0, bc);
    endtask

    initial begin
        bus.dut_run = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            imem[i] = 16'($urandom);
            wmem[i] = 16'($urandom);
        end
        test_reset();
        test_single_3x3();
        test_two_kernels_zero();
        test_two_images();
        test_thresholds();
        test_bad_dim();
        test_bad_k();
        test_terminator();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
